pipelined_lookup_mem: RTL and testbench

Parametrised, pipelined successor to the single-level address-to-data memory leaf at the bottom of the hierarchy. It holds a `DEPTH`-word array whose contents reset to the identity map (word i = i), so an unwritten location returns its own index, exactly like the combinational leaf it replaces. Reads pass through a `LATENCY`-stage registered pipeline with valid/ready handshakes on request and response, and an optional write port. It instantiates one level below the existing wrapper chain, in place of the leaf.

---
 rtl/pipelined_lookup_mem.sv | 88 ++++++++
 tb/tb_pipelined_lookup_mem.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_lookup_mem.sv
// rtl/pipelined_lookup_mem.sv - pipelined identity-initialised lookup memory with valid/ready handshakes
// Optional write port enabled by defining PIPE_MEM_WRITE_EN; otherwise an identity ROM.
module pipelined_lookup_mem #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDX_W-1:0]      idx;
  logic                  advance;
  logic                  accept;
  logic                  is_write;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [LATENCY-1:0]    stage_valid;
  logic [DATA_WIDTH-1:0] stage_data [LATENCY];

  // Upper address bits only alias; they never select anything.
  logic [ADDR_WIDTH-1:0] unused_addr_bits;
  assign unused_addr_bits = addr;

  assign idx = addr[IDX_W-1:0];

`ifdef PIPE_MEM_WRITE_EN
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign is_write = req_write;
  assign rd_data  = mem[idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_WIDTH'(i);
      end
    end else if (accept && req_write) begin
      mem[idx] <= wdata;
    end
  end
`else
  logic [DATA_WIDTH:0] unused_write_bits;
  assign unused_write_bits = {req_write, wdata};

  assign is_write = 1'b0;
  assign rd_data  = DATA_WIDTH'(idx);
`endif

  // The whole pipeline freezes on a stalled output, so bubbles are preserved.
  assign resp_valid = stage_valid[LATENCY-1];
  assign resp_data  = stage_data[LATENCY-1];
  assign advance    = !resp_valid || resp_ready;
  assign req_ready  = advance;
  assign accept     = req_valid && advance;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        stage_data[i] <= '0;
      end
    end else if (advance) begin
      stage_valid[0] <= accept && !is_write;
      if (accept && !is_write) begin
        stage_data[0] <= rd_data;
      end
      // Invalid stages keep their previous data to avoid needless toggling.
      for (int n = 1; n < LATENCY; n++) begin
        stage_valid[n] <= stage_valid[n-1];
        if (stage_valid[n-1]) begin
          stage_data[n] <= stage_data[n-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_lookup_mem.sv
// tb/tb_pipelined_lookup_mem.sv - scoreboard bench for pipelined_lookup_mem
// Expected write behaviour follows PIPE_MEM_WRITE_EN.
module tb_pipelined_lookup_mem;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int DEP = 16;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model [DEP];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  pipelined_lookup_mem #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEP; i++) model[i] = DW'(i);
  endtask

  // Response checking and request modelling, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (resp_valid) begin
        if (prev_stall) check("stall_hold_data", 32'(resp_data), 32'(prev_data));
        if (resp_ready) begin
          if (exp_q.size() == 0) check("unexpected_resp", 32'(resp_data), 32'hFFFF_FFFF);
          else check("resp_data", 32'(resp_data), 32'(exp_q.pop_front()));
        end
      end else if (prev_stall) begin
        check("stall_hold_valid", 32'(resp_valid), 32'd1);
      end
      prev_stall = resp_valid && !resp_ready;
      prev_data  = resp_data;
      if (req_valid && req_ready) begin
`ifdef PIPE_MEM_WRITE_EN
        if (req_write) model[addr % DEP] = wdata;
        else exp_q.push_back(model[addr % DEP]);
`else
        exp_q.push_back(model[addr % DEP]);
`endif
      end
    end
  end

  task automatic rand_ready(input bit rnd);
    if (rnd) resp_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Present a request and return just after the edge that accepts it.
  task automatic send(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d, input bit rnd);
    int waits = 0;
    req_valid = 1'b1; req_write = w; addr = a; wdata = d;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      waits++;
      if (waits > 200) begin
        check("send_timeout", 32'(waits), 32'd0);
        break;
      end
      @(posedge clk); #1;
      rand_ready(rnd);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rand_ready(rnd);
  endtask

  task automatic drain();
    int waits = 0;
    resp_ready = 1'b1;
    while ((exp_q.size() != 0 || resp_valid) && waits < 100) begin
      @(posedge clk); #1;
      waits++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; addr = '0; wdata = '0; resp_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;

    // Back-to-back reads 5,6,7: first response visible after the third edge.
    send(16'd5, 1'b0, '0, 1'b0);
    check("lat_edge1_valid", 32'(resp_valid), 32'd0);
    send(16'd6, 1'b0, '0, 1'b0);
    check("lat_edge2_valid", 32'(resp_valid), 32'd0);
    send(16'd7, 1'b0, '0, 1'b0);
    check("lat_edge3_valid", 32'(resp_valid), 32'd1);
    check("lat_edge3_data", 32'(resp_data), 32'd5);
    drain();

    // Write then read same index next cycle, then an aliased address.
    send(16'd3, 1'b1, 16'hBEEF, 1'b0);
    send(16'd3, 1'b0, '0, 1'b0);
    send(16'h0013, 1'b0, '0, 1'b0);
    drain();

    // Backpressure: freeze with a full pipeline and a pending request.
    resp_ready = 1'b0;
    send(16'd10, 1'b0, '0, 1'b0);
    send(16'd11, 1'b0, '0, 1'b0);
    send(16'd12, 1'b0, '0, 1'b0);
    req_valid = 1'b1; req_write = 1'b0; addr = 16'd13;
    repeat (5) begin
      @(negedge clk);
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    send(16'd13, 1'b0, '0, 1'b0);
    drain();

    // Interleaved writes and reads to one index.
    send(16'd2, 1'b1, 16'h0011, 1'b0);
    send(16'd2, 1'b0, '0, 1'b0);
    send(16'd2, 1'b1, 16'h0022, 1'b0);
    send(16'd2, 1'b0, '0, 1'b0);
    drain();

    // Write 0x1234 to 9 then read 9.
    send(16'd9, 1'b1, 16'h1234, 1'b0);
    send(16'd9, 1'b0, '0, 1'b0);
    drain();

    // Reset with reads in flight discards them and restores identity.
    send(16'd1, 1'b1, 16'hAAAA, 1'b0);
    send(16'd4, 1'b0, '0, 1'b0);
    send(16'd5, 1'b0, '0, 1'b0);
    send(16'd6, 1'b0, '0, 1'b0);
    check("inflight_valid", 32'(resp_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(resp_valid), 32'd0);
    check("async_rst_ready", 32'(req_ready), 32'd1);
    exp_q.delete();
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    send(16'd1, 1'b0, '0, 1'b0);
    drain();

    // Mixed random traffic with random consumer backpressure.
    for (int i = 0; i < 40; i++) begin
      send(16'($urandom), ($urandom_range(0, 9) < 3), 16'($urandom), 1'b1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
